// File: rtl/wb_dcache_mem_adapter_pkg.sv
// Shared definitions for the data-cache to data-memory burst adapter:
// default geometry, derived burst constants and the adapter state encoding.
package wb_dcache_mem_adapter_pkg;

    localparam int DMEM_ADDR_WIDTH   = 32;
    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DMEM_DATA_WIDTH   = 32;
    localparam int DMEM_BEATS        = DCACHE_LINE_WIDTH / DMEM_DATA_WIDTH;
    localparam int DMEM_OFFSET_BITS  = $clog2(DCACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } type_dmem_adapter_states_e;

    // True when n is a non-zero power of two.
    function automatic logic is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/wb_dcache_mem_adapter_if.sv
// Line-wide cache memory port and word-wide data-memory bus seen by the adapter.
// The cache is master of dcache_mem_if; the adapter is master of dmem_bus_if.
interface dcache_mem_if
    import wb_dcache_mem_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH
);
    logic                  dcache2mem_req;
    logic                  dcache2mem_wr;
    logic [ADDR_WIDTH-1:0] dcache2mem_addr;
    logic [LINE_WIDTH-1:0] dcache2mem_wdata;
    logic                  mem2dcache_ack;
    logic [LINE_WIDTH-1:0] mem2dcache_rdata;

    modport master (
        output dcache2mem_req, dcache2mem_wr, dcache2mem_addr, dcache2mem_wdata,
        input  mem2dcache_ack, mem2dcache_rdata
    );

    modport slave (
        input  dcache2mem_req, dcache2mem_wr, dcache2mem_addr, dcache2mem_wdata,
        output mem2dcache_ack, mem2dcache_rdata
    );
endinterface

interface dmem_bus_if
    import wb_dcache_mem_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
);
    logic                    bus_req;
    logic                    bus_we;
    logic [ADDR_WIDTH-1:0]   bus_addr;
    logic [DATA_WIDTH-1:0]   bus_wdata;
    logic [DATA_WIDTH/8-1:0] bus_sel;
    logic                    bus_ack;
    logic [DATA_WIDTH-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/wb_dcache_mem_adapter.sv
// Turns each cache line refill / write-back into an incrementing burst of
// single-word bus transactions; refill beats are assembled into a line.
module wb_dcache_mem_adapter
    import wb_dcache_mem_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    dcache_mem_if.slave cache,
    dmem_bus_if.master  bus
);

    localparam int BEATS     = LINE_WIDTH / DATA_WIDTH;
    localparam int BEAT_BITS = $clog2(BEATS);
    localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int WORD_BITS = $clog2(DATA_WIDTH);
    localparam int OFFSET    = BEAT_BITS + BYTE_BITS;
    localparam int TAG_W     = ADDR_WIDTH - OFFSET;
    localparam int SEL_W     = DATA_WIDTH / 8;
    localparam int IDX_W     = BEAT_BITS + WORD_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    if (((LINE_WIDTH % DATA_WIDTH) != 0) || !is_pow2(BEATS) || (BEATS < 2)) begin : g_bad_geometry
        $error("wb_dcache_mem_adapter: LINE_WIDTH/DATA_WIDTH must be a power of two >= 2");
    end

    type_dmem_adapter_states_e state_r;
    logic [BEAT_BITS-1:0]      beat_r;
    logic [TAG_W-1:0]          tag_r;
    logic                      wr_r;
    logic [LINE_WIDTH-1:0]     wdata_r;
    logic [LINE_WIDTH-1:0]     rbuf_r;

    logic                      bus_req_r;
    logic                      bus_we_r;
    logic [ADDR_WIDTH-1:0]     bus_addr_r;
    logic [DATA_WIDTH-1:0]     bus_wdata_r;
    logic [SEL_W-1:0]          bus_sel_r;
    logic                      ack_r;

    logic [BEAT_BITS-1:0]      beat_nxt_s;
    logic                      last_beat_s;
    logic [IDX_W-1:0]          rd_idx_s;
    logic [IDX_W-1:0]          wr_idx_s;
    logic                      unused_offset_s;

    // Offset bits of the incoming line address carry no meaning here.
    assign unused_offset_s = ^cache.dcache2mem_addr[OFFSET-1:0];

    // Next-beat index and bit offsets into the line for the current and next beat.
    always_comb begin
        beat_nxt_s  = beat_r + {{(BEAT_BITS-1){1'b0}}, 1'b1};
        last_beat_s = (beat_r == LAST_BEAT);
        rd_idx_s    = {beat_r, {WORD_BITS{1'b0}}};
        wr_idx_s    = {beat_nxt_s, {WORD_BITS{1'b0}}};
    end

    // Burst sequencer: latches the line request, steps beats on bus_ack and
    // drives every bus/cache output from registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            beat_r      <= {BEAT_BITS{1'b0}};
            tag_r       <= {TAG_W{1'b0}};
            wr_r        <= 1'b0;
            wdata_r     <= {LINE_WIDTH{1'b0}};
            rbuf_r      <= {LINE_WIDTH{1'b0}};
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
            bus_wdata_r <= {DATA_WIDTH{1'b0}};
            bus_sel_r   <= {SEL_W{1'b0}};
            ack_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 1'b0;
                    if (cache.dcache2mem_req) begin
                        state_r     <= BEAT;
                        beat_r      <= {BEAT_BITS{1'b0}};
                        tag_r       <= cache.dcache2mem_addr[ADDR_WIDTH-1:OFFSET];
                        wr_r        <= cache.dcache2mem_wr;
                        wdata_r     <= cache.dcache2mem_wdata;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= cache.dcache2mem_wr;
                        bus_addr_r  <= {cache.dcache2mem_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
                        bus_wdata_r <= cache.dcache2mem_wdata[DATA_WIDTH-1:0];
                        bus_sel_r   <= {SEL_W{1'b1}};
                    end
                end
                BEAT: begin
                    if (bus.bus_ack) begin
                        if (!wr_r) begin
                            rbuf_r[rd_idx_s +: DATA_WIDTH] <= bus.bus_rdata;
                        end
                        if (last_beat_s) begin
                            state_r     <= DONE;
                            bus_req_r   <= 1'b0;
                            bus_we_r    <= 1'b0;
                            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
                            bus_wdata_r <= {DATA_WIDTH{1'b0}};
                            bus_sel_r   <= {SEL_W{1'b0}};
                            ack_r       <= 1'b1;
                        end else begin
                            beat_r      <= beat_nxt_s;
                            bus_addr_r  <= {tag_r, beat_nxt_s, {BYTE_BITS{1'b0}}};
                            bus_wdata_r <= wdata_r[wr_idx_s +: DATA_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    beat_r  <= {BEAT_BITS{1'b0}};
                    ack_r   <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    beat_r      <= {BEAT_BITS{1'b0}};
                    bus_req_r   <= 1'b0;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= {ADDR_WIDTH{1'b0}};
                    bus_wdata_r <= {DATA_WIDTH{1'b0}};
                    bus_sel_r   <= {SEL_W{1'b0}};
                    ack_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_req            = bus_req_r;
    assign bus.bus_we             = bus_we_r;
    assign bus.bus_addr           = bus_addr_r;
    assign bus.bus_wdata          = bus_wdata_r;
    assign bus.bus_sel            = bus_sel_r;
    assign cache.mem2dcache_ack   = ack_r;
    assign cache.mem2dcache_rdata = rbuf_r;

endmodule

// File: doc/wb_dcache_mem_adapter.md
# wb_dcache_mem_adapter

Sits directly downstream of the write-back data cache, between its line-wide memory port and the word-wide data-memory bus. Each cache line read (refill) or line write (write-back) becomes a fixed, incrementing burst of single-word bus transactions. Read beats are assembled into a full line and returned to the cache with a single-cycle acknowledge.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width on both sides.
- `LINE_WIDTH`, 128: cache line width in bits.
- `DATA_WIDTH`, 32: bus word width in bits. `BEATS = LINE_WIDTH/DATA_WIDTH` must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic rising-edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `dcache2mem_req_i`  in  1  line request from cache, held until ack.
- `dcache2mem_wr_i`  in  1  1 = line write-back, 0 = line refill.
- `dcache2mem_addr_i`  in  ADDR_WIDTH  line address; offset bits ignored.
- `dcache2mem_wdata_i`  in  LINE_WIDTH  line to write.
- `mem2dcache_ack_o`  out  1  single-cycle line completion.
- `mem2dcache_rdata_o`  out  LINE_WIDTH  assembled refill line.
- `bus_req_o`  out  1  word request.
- `bus_we_o`  out  1  word write enable.
- `bus_addr_o`  out  ADDR_WIDTH  word byte address.
- `bus_wdata_o`  out  DATA_WIDTH  write word.
- `bus_sel_o`  out  DATA_WIDTH/8  byte selects, all ones while `bus_req_o` is high.
- `bus_ack_i`  in  1  word completion, sampled only while `bus_req_o` is high.
- `bus_rdata_i`  in  DATA_WIDTH  read word, valid with `bus_ack_i`.

## Operation
- FSM states: IDLE, BEAT, DONE.
- IDLE, `dcache2mem_req_i`=1:
  - latch line address with offset cleared (`OFFSET = log2(LINE_WIDTH/8)`), `wr`, and `wdata`
  - beat counter ← 0, go to BEAT.
- BEAT:
  - `bus_req_o`=1, `bus_we_o`=latched `wr`.
  - `bus_addr_o = {line_addr[ADDR_WIDTH-1:OFFSET], beat, {log2(DATA_WIDTH/8){0}}}`.
  - `bus_wdata_o = wdata[beat*DATA_WIDTH +: DATA_WIDTH]`.
- On `bus_ack_i` in BEAT:
  - read: `rbuf[beat*DATA_WIDTH +: DATA_WIDTH] ← bus_rdata_i`.
  - if `beat == BEATS-1`, go to DONE; else increment beat and stay in BEAT.
- DONE: `mem2dcache_ack_o`=1 for exactly one cycle, then go to IDLE.
- Beat order is always incrementing from 0; no critical-word-first, no wrap.
- `mem2dcache_rdata_o` = `rbuf`:
  - unchanged by write transactions
  - holds its value until the next refill overwrites it beat by beat.
- Cache inputs are ignored outside IDLE; changes mid-burst have no effect (the latch happens in IDLE).
- Contract: the cache deasserts `req` in the cycle after `ack`. A `req` still high in IDLE is a new transaction.
- No bus error handling; an ack that never arrives stalls the FSM in BEAT indefinitely.

## Timing
- Reset values (async, immediate):
  - state IDLE, beat 0, `rbuf` 0
  - all outputs 0 (`bus_sel_o` 0)
- All outputs are registered or decoded from registered state only; no combinational path from `bus_ack_i` to bus outputs.
- Cycle of `bus_ack_i`: the next beat's address and data appear on the following edge. `bus_req_o` stays high continuously across beats.
- Zero-wait bus (ack in every BEAT cycle):
  - req sampled at cycle 0, beats at cycles 1..BEATS, `mem2dcache_ack_o` at cycle BEATS+1 (cycle 5 for defaults).
  - Each bus wait state adds one cycle.
- Minimum gap between line transactions: one IDLE cycle after DONE.
- Reset asserted mid-burst:
  - aborts immediately; `bus_req_o` drops asynchronously; no ack is issued.
  - partial `rbuf` is cleared.

## Structure
- `cache_defs.svh` gains:
  - `DCACHE_LINE_WIDTH`, `DMEM_DATA_WIDTH`, and derived `DMEM_BEATS`/`DMEM_OFFSET_BITS`
  - `type_dmem_adapter_states_e` enum (IDLE, BEAT, DONE).
- Single flat module; the beat counter and line buffer stay inline. No sub-module is warranted.
- Elaboration-time check that `LINE_WIDTH % DATA_WIDTH == 0` and that `BEATS` is a power of two.

## Test plan
- Refill, addr 0x8000_0014, zero-wait bus, words 0x11,0x22,0x33,0x44:
  - bus addresses 0x8000_0010/14/18/1C
  - `mem2dcache_ack_o` at cycle 5
  - `rdata` = 0x00000044_00000033_00000022_00000011.
- Write-back, addr 0x0000_1000, line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA:
  - `bus_we_o`=1, `bus_sel_o`=0xF
  - `bus_wdata_o` sequence AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD
  - `rdata` unchanged.
- Refill with 2 wait states per beat: ack at cycle 13; addresses hold stable through the wait cycles.
- Cache changes `addr`/`wdata` mid-burst: bus outputs keep the latched values.
- Reset asserted after beat 1 ack: outputs 0 immediately, no `mem2dcache_ack_o`; a new refill after reset completes normally.
- Back-to-back: `req` held high one cycle past ack → second transaction starts from IDLE; exactly one IDLE cycle between the bursts.
